// File: rtl/pwm_audio_out.sv
// pwm_audio_out: one-sample buffered PWM audio DAC driver; period = 2^DATA_BITS clocks.
// Latency: a sample accepted in period P drives pwm_out for all of period P+1 (one clock after its period_start).
// Backpressure: din_ready = ~buf_full (registered); the buffer drains only at the period boundary.
// Optional feature macro: PWM_AUDIO_OUT_VOLUME_EN adds vol_shift (right-shift attenuation at capture).
module pwm_audio_out #(
    parameter int DATA_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 din_valid,
`ifdef PWM_AUDIO_OUT_VOLUME_EN
    input  logic [2:0]           vol_shift,
`endif
    output logic                 din_ready,
    output logic                 pwm_out,
    output logic                 period_start,
    output logic [7:0]           underrun_cnt
);

    localparam logic [DATA_BITS-1:0] CNT_MAX = '1;
    localparam logic [DATA_BITS-1:0] CNT_ONE = DATA_BITS'(1);

    logic [DATA_BITS-1:0] cnt;
    logic [DATA_BITS-1:0] duty;
    logic [DATA_BITS-1:0] buf_dat;
    logic                 buf_full;
    logic [DATA_BITS-1:0] sample_in;
    logic                 boundary;
    logic                 xfer;

    // Ready depends only on the buffer flag, never on din_valid.
    assign din_ready    = ~buf_full;
    assign xfer         = din_valid & ~buf_full;
    assign boundary     = (cnt == CNT_MAX);
    assign period_start = (cnt == '0);

`ifdef PWM_AUDIO_OUT_VOLUME_EN
    assign sample_in = din >> vol_shift;
`else
    assign sample_in = din;
`endif

    // Free-running period counter, wraps naturally at 2^DATA_BITS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // One-entry sample buffer: filled on transfer, drained into duty at the boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_dat  <= '0;
            buf_full <= 1'b0;
        end else if (boundary && buf_full) begin
            buf_full <= 1'b0;
        end else if (xfer) begin
            buf_dat  <= sample_in;
            buf_full <= 1'b1;
        end
    end

    // Duty only changes at the boundary so each period is a whole, glitch-free pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty <= '0;
        end else if (boundary && buf_full) begin
            duty <= buf_dat;
        end
    end

    // Count periods that start without a fresh sample; saturate instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt <= 8'd0;
        end else if (boundary && !buf_full && (underrun_cnt != 8'hFF)) begin
            underrun_cnt <= underrun_cnt + 8'd1;
        end
    end

    // Registered comparator output, one clock behind cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= (cnt < duty);
        end
    end

endmodule

// File: tb/tb_pwm_audio_out.sv
// tb_pwm_audio_out: directed checks of pwm_audio_out with DATA_BITS=4 (16-clock period).
// Inputs are driven and outputs sampled on the falling edge of clk.
// Period alignment is tracked by cycle counts from reset release.
module tb_pwm_audio_out;

    logic       clk;
    logic       rst_n;
    logic [3:0] din;
    logic       din_valid;
    logic [2:0] vol_shift;
    logic       din_ready;
    logic       pwm_out;
    logic       period_start;
    logic [7:0] underrun_cnt;

    int total;
    int passed;

    pwm_audio_out #(.DATA_BITS(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din          (din),
        .din_valid    (din_valid),
`ifdef PWM_AUDIO_OUT_VOLUME_EN
        .vol_shift    (vol_shift),
`endif
        .din_ready    (din_ready),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .underrun_cnt (underrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one full period starting at the falling edge where cnt=0; optionally offers
    // one sample for the first cycle. Returns high-clock count and ready at cnt=1 / cnt=15.
    task automatic run_period(input logic send, input logic [3:0] d,
                              output int n, output logic rdy_mid, output logic rdy_end);
        n = 0;
        rdy_mid = 1'b1;
        rdy_end = 1'b1;
        if (send) begin
            din = d;
            din_valid = 1'b1;
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) begin
                din_valid = 1'b0;
                rdy_mid = din_ready;
            end
            if (i == 14) rdy_end = din_ready;
            if (pwm_out === 1'b1) n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        din = 4'd7;
        din_valid = 1'b1;
        vol_shift = 3'd0;
        repeat (3) @(negedge clk);
        total++; if (pwm_out !== 1'b0) $display("FAIL reset_pwm: got %b want 0", pwm_out); else passed++;
        total++; if (din_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", din_ready); else passed++;
        total++; if (period_start !== 1'b1) $display("FAIL reset_period_start: got %b want 1", period_start); else passed++;
        total++; if (underrun_cnt !== 8'd0) $display("FAIL reset_underrun: got %0d want 0", underrun_cnt); else passed++;
        din_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (period_start !== 1'b0) $display("FAIL release_cnt1: period_start got %b want 0", period_start); else passed++;
        total++; if (din_ready !== 1'b1) $display("FAIL reset_ignored_xfer: ready got %b want 1", din_ready); else passed++;
        repeat (15) @(negedge clk);
        total++; if (period_start !== 1'b1) $display("FAIL release_wrap: period_start got %b want 1", period_start); else passed++;
        total++; if (underrun_cnt !== 8'd1) $display("FAIL first_underrun: got %0d want 1", underrun_cnt); else passed++;
        total++; if (pwm_out !== 1'b0) $display("FAIL idle_pwm: got %b want 0", pwm_out); else passed++;
    endtask

    task automatic test_basic;
        int n; logic rm, re;
        run_period(1'b1, 4'd4, n, rm, re);
        total++; if (n !== 0) $display("FAIL basic_p0_high: got %0d want 0", n); else passed++;
        total++; if (rm !== 1'b0) $display("FAIL basic_ready_mid: got %b want 0", rm); else passed++;
        total++; if (re !== 1'b0) $display("FAIL basic_ready_end: got %b want 0", re); else passed++;
        total++; if (din_ready !== 1'b1) $display("FAIL basic_ready_after: got %b want 1", din_ready); else passed++;
        total++; if (underrun_cnt !== 8'd1) $display("FAIL basic_no_underrun: got %0d want 1", underrun_cnt); else passed++;
        run_period(1'b0, 4'd0, n, rm, re);
        total++; if (n !== 4) $display("FAIL basic_p1_high: got %0d want 4", n); else passed++;
        total++; if (underrun_cnt !== 8'd2) $display("FAIL basic_underrun: got %0d want 2", underrun_cnt); else passed++;
    endtask

    task automatic test_extremes;
        int n; logic rm, re;
        run_period(1'b1, 4'd0, n, rm, re);
        total++; if (n !== 4) $display("FAIL ext_held4: got %0d want 4", n); else passed++;
        run_period(1'b1, 4'd15, n, rm, re);
        total++; if (n !== 0) $display("FAIL ext_duty0: got %0d want 0", n); else passed++;
        run_period(1'b0, 4'd0, n, rm, re);
        total++; if (n !== 15) $display("FAIL ext_duty15: got %0d want 15", n); else passed++;
        total++; if (underrun_cnt !== 8'd3) $display("FAIL ext_underrun: got %0d want 3", underrun_cnt); else passed++;
    endtask

    task automatic test_back_to_back;
        int n; logic rm, re;
        din = 4'd3;
        din_valid = 1'b1;
        @(negedge clk);                 // cnt=1, sample 3 buffered
        din = 4'd9;                     // held valid against a full buffer
        total++; if (din_ready !== 1'b0) $display("FAIL b2b_full: ready got %b want 0", din_ready); else passed++;
        repeat (14) @(negedge clk);     // cnt=15, boundary cycle
        total++; if (din_ready !== 1'b0) $display("FAIL b2b_boundary: ready got %b want 0", din_ready); else passed++;
        @(negedge clk);                 // cnt=0, buffer drained, transfer this cycle
        total++; if (din_ready !== 1'b1) $display("FAIL b2b_after: ready got %b want 1", din_ready); else passed++;
        n = 0;
        @(negedge clk);                 // cnt=1, exactly one transfer taken
        din_valid = 1'b0;
        total++; if (din_ready !== 1'b0) $display("FAIL b2b_one_xfer: ready got %b want 0", din_ready); else passed++;
        if (pwm_out === 1'b1) n++;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (pwm_out === 1'b1) n++;
        end
        total++; if (n !== 3) $display("FAIL b2b_duty3: got %0d want 3", n); else passed++;
        run_period(1'b0, 4'd0, n, rm, re);
        total++; if (n !== 9) $display("FAIL b2b_duty9: got %0d want 9", n); else passed++;
        total++; if (underrun_cnt !== 8'd4) $display("FAIL b2b_no_dup: underrun got %0d want 4", underrun_cnt); else passed++;
    endtask

    task automatic test_underrun_sat;
        int n; logic rm, re;
        for (int p = 0; p < 250; p++) run_period(1'b0, 4'd0, n, rm, re);
        total++; if (underrun_cnt !== 8'd254) $display("FAIL sat_254: got %0d want 254", underrun_cnt); else passed++;
        for (int p = 0; p < 50; p++) run_period(1'b0, 4'd0, n, rm, re);
        total++; if (underrun_cnt !== 8'd255) $display("FAIL sat_255: got %0d want 255", underrun_cnt); else passed++;
        total++; if (n !== 9) $display("FAIL sat_duty_held: got %0d want 9", n); else passed++;
    endtask

`ifdef PWM_AUDIO_OUT_VOLUME_EN
    task automatic test_volume;
        int n; logic rm, re;
        vol_shift = 3'd2;
        run_period(1'b1, 4'd12, n, rm, re);
        vol_shift = 3'd0;
        run_period(1'b0, 4'd0, n, rm, re);
        total++; if (n !== 3) $display("FAIL vol_shift2: got %0d want 3", n); else passed++;
    endtask
`endif

    task automatic test_mid_reset;
        int n; logic rm, re;
        din = 4'd6;
        din_valid = 1'b1;
        repeat (5) @(negedge clk);      // cnt=5, sample 6 buffered
        din_valid = 1'b0;
        total++; if (pwm_out !== 1'b1) $display("FAIL mid_pre_pwm: got %b want 1", pwm_out); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (pwm_out !== 1'b0) $display("FAIL mid_async_pwm: got %b want 0", pwm_out); else passed++;
        total++; if (din_ready !== 1'b1) $display("FAIL mid_async_ready: got %b want 1", din_ready); else passed++;
        total++; if (period_start !== 1'b1) $display("FAIL mid_async_cnt: period_start got %b want 1", period_start); else passed++;
        total++; if (underrun_cnt !== 8'd0) $display("FAIL mid_async_underrun: got %0d want 0", underrun_cnt); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        run_period(1'b0, 4'd0, n, rm, re);
        total++; if (n !== 0) $display("FAIL mid_discard: high got %0d want 0", n); else passed++;
        total++; if (underrun_cnt !== 8'd1) $display("FAIL mid_underrun: got %0d want 1", underrun_cnt); else passed++;
        total++; if (period_start !== 1'b1) $display("FAIL mid_restart: period_start got %b want 1", period_start); else passed++;
    endtask

    initial begin
        total = 0;
        passed = 0;
        test_reset;
        test_basic;
        test_extremes;
        test_back_to_back;
        test_underrun_sat;
`ifdef PWM_AUDIO_OUT_VOLUME_EN
        test_volume;
`endif
        test_mid_reset;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
